// File: rtl/pipe_register_pkg.sv
// Shared definitions for the pipe_register block: the legal stage-count
// range and the width of the occupancy counter.
package pipe_register_pkg;

  // Legal range for the number of register stages.
  localparam int MIN_DEPTH = 1;
  localparam int MAX_DEPTH = 8;

  // Bits needed to count from 0 up to and including depth entries.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // True when depth is a stage count the block can be built with.
  function automatic bit depth_legal(input int depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
  endfunction

endpackage : pipe_register_pkg

// File: rtl/pipe_register_stage.sv
// One register slot of the pipe: a valid bit, a data word, and its link
// in the backward ready chain. A slot is ready when it is empty or when the
// slot after it is ready, so holes in the pipe are filled while the output
// is stalled.
module pipe_register_stage
  import pipe_register_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Ready chain link: empty slots always take data, full ones only move on.
  assign ready = !valid || down_ready;

  // Valid bit: cleared by flush, otherwise follows upstream whenever the slot may move.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking (<=) so every slot samples the pre-edge values of its neighbours.
    if (!rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
    end
  end

  // Data word: captured only when a real entry moves in, held otherwise (including on flush).
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: these are ordinary flops, so they take RESET_VAL; a RAM-backed buffer would leave its contents unreset.
    if (!rst) begin
      data <= RESET_VAL;
    end else if (ready && up_valid && !flush) begin
      data <= up_data;
    end
  end

endmodule : pipe_register_stage

// File: rtl/pipe_register.sv
// Valid/ready register pipeline of DEPTH slots with flush and an occupancy
// counter. Stage 0 faces the input, stage DEPTH-1 drives the output. Every
// output is taken from a flop, so nothing on the input side reaches
// out_valid/out_data within a cycle.
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [count_width(DEPTH)-1:0]  count
);

  localparam int COUNT_W = count_width(DEPTH);

  // Refuse to build with an unsupported shape.
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("pipe_register: DEPTH=%0d outside %0d..%0d", DEPTH, MIN_DEPTH, MAX_DEPTH);
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_register: WIDTH=%0d must be at least 1", WIDTH);
  end

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             down_ready;
    logic             ready;

    // Upstream side: the input port for stage 0, the previous slot otherwise.
    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_link
      assign up_valid = v[i-1];
      assign up_data  = d[i-1];
    end

    // Downstream side: the output port for the last stage, the next slot otherwise.
    // Each link is its own net so the chain never looks like a loop.
    if (i == DEPTH - 1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_mid
      assign down_ready = g_stage[i+1].ready;
    end

    pipe_register_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (down_ready),
      .ready      (ready),
      .valid      (v[i]),
      .data       (d[i])
    );
  end

  // Flush blocks acceptance so an entry offered during a flush is never taken.
  assign in_ready  = g_stage[0].ready && !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Occupancy: entries only enter through in_xfer and leave through out_xfer or flush,
  // so this tracks the number of set valid bits exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + COUNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      count <= count - COUNT_W'(1);
    end
  end

endmodule : pipe_register

// File: tb/tb_pipe_register.sv
// Self-checking bench for pipe_register: directed scenarios on a 3-deep,
// 32-bit pipe, then random traffic on the 3-deep and a 1-deep pipe checked
// against FIFO models (a pipe is a bounded FIFO: accepts while below
// capacity or while the head leaves, emits entries in arrival order).
module tb_pipe_register;

  localparam int W   = 32;
  localparam int D3  = 3;
  localparam int D1  = 1;
  localparam int CW3 = $clog2(D3 + 1);
  localparam int CW1 = $clog2(D1 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic           a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [W-1:0]   a_in_data, a_out_data;
  logic [CW3-1:0] a_count;

  logic           b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0]   b_in_data, b_out_data;
  logic [CW1-1:0] b_count;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q3 [$];
  logic [W-1:0] q1 [$];

  pipe_register #(.WIDTH(W), .DEPTH(D3), .RESET_VAL(32'h0)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .count     (a_count)
  );

  pipe_register #(.WIDTH(W), .DEPTH(D1), .RESET_VAL(32'h0)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .count     (b_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] vals [4];
    int           cnt_tab [4];
    int           exp_cnt;
    bit           got;
    int           seen_at;
    logic         exp_rdy;

    rst = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    // Reset, released between clock edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(a_out_valid), 64'(0));
    check("rst_out_data",  64'(a_out_data),  64'(0));
    check("rst_count",     64'(a_count),     64'(0));
    check("rst_in_ready",  64'(a_in_ready),  64'(1));
    check("rst1_out_valid", 64'(b_out_valid), 64'(0));
    check("rst1_count",     64'(b_count),     64'(0));
    tick();

    // Streaming 1..4 at full rate: each value appears 3 cycles after acceptance.
    a_out_ready = 1'b1;
    exp_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      a_in_valid = (c < 4);
      a_in_data  = 32'(c + 1);
      @(negedge clk);
      check("stream_in_ready",  64'(a_in_ready),  64'(1));
      check("stream_count",     64'(a_count),     64'(exp_cnt));
      check("stream_out_valid", 64'(a_out_valid), 64'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check("stream_out_data", 64'(a_out_data), 64'(c - 2));
      if (c < 4) exp_cnt++;
      if (c >= 3 && c <= 6) exp_cnt--;
      tick();
    end
    a_in_valid = 1'b0;

    // Stall: three entries fill the pipe, the fourth waits.
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC; vals[3] = 32'hD;
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = vals[k];
      @(negedge clk);
      check("fill_in_ready", 64'(a_in_ready), 64'(1));
      check("fill_count",    64'(a_count),    64'(k));
      tick();
    end
    a_in_data = vals[3];
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check("full_in_ready",  64'(a_in_ready),  64'(0));
      check("full_count",     64'(a_count),     64'(3));
      check("full_out_valid", 64'(a_out_valid), 64'(1));
      check("full_out_data",  64'(a_out_data),  64'(vals[0]));
      tick();
    end
    a_out_ready = 1'b1;
    cnt_tab[0] = 3; cnt_tab[1] = 3; cnt_tab[2] = 2; cnt_tab[3] = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) check("drain_in_ready", 64'(a_in_ready), 64'(1));
      check("drain_out_valid", 64'(a_out_valid), 64'(1));
      check("drain_out_data",  64'(a_out_data),  64'(vals[k]));
      check("drain_count",     64'(a_count),     64'(cnt_tab[k]));
      tick();
      a_in_valid = 1'b0;
    end
    @(negedge clk);
    check("drain_empty_valid", 64'(a_out_valid), 64'(0));
    check("drain_empty_count", 64'(a_count),     64'(0));
    tick();

    // Flush with two entries held, colliding with an input and an output transfer.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h30; tick();
    a_in_data = 32'h31; tick();
    a_in_valid = 1'b0; tick();
    @(negedge clk);
    check("preflush_count",     64'(a_count),     64'(2));
    check("preflush_out_valid", 64'(a_out_valid), 64'(1));
    check("preflush_out_data",  64'(a_out_data),  64'(32'h30));
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hEE; a_out_ready = 1'b1;
    #1;
    check("flush_in_ready", 64'(a_in_ready), 64'(0));
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(a_out_valid), 64'(0));
    check("flush_count",     64'(a_count),     64'(0));
    check("flush_data_held", 64'(a_out_data),  64'(32'h30));
    tick();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("flush_no_ee", 64'(a_out_valid), 64'(0));
      tick();
    end

    // Asynchronous reset mid-stream with two entries held.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h20; tick();
    a_in_data = 32'h21; tick();
    a_in_valid = 1'b0; tick();
    @(negedge clk);
    check("prerst_count", 64'(a_count), 64'(2));
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(a_out_valid), 64'(0));
    check("arst_out_data",  64'(a_out_data),  64'(0));
    check("arst_count",     64'(a_count),     64'(0));
    check("arst_in_ready",  64'(a_in_ready),  64'(1));
    #1;
    rst = 1'b1;
    tick();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h55;
    @(negedge clk);
    check("post_rst_in_ready", 64'(a_in_ready), 64'(1));
    tick();
    a_in_valid = 1'b0;
    got = 1'b0;
    seen_at = -1;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (a_out_valid) begin
        got = 1'b1;
        seen_at = w;
        check("post_rst_first_out", 64'(a_out_data), 64'(32'h55));
      end
      tick();
    end
    check("post_rst_out_seen",    64'(got),     64'(1));
    check("post_rst_out_latency", 64'(seen_at), 64'(2));

    // Random traffic on both pipes, checked against bounded-FIFO models.
    q3.delete();
    q1.delete();
    for (int n = 0; n < 1000; n++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_data   = $urandom();
      a_flush     = ($urandom_range(0, 31) == 0);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_data   = $urandom();
      b_flush     = 1'b0;
      @(negedge clk);

      exp_rdy = (a_out_ready || q3.size() < D3) && !a_flush;
      check("rnd3_count",    64'(a_count),    64'(q3.size()));
      check("rnd3_in_ready", 64'(a_in_ready), 64'(exp_rdy));
      check("rnd3_valid_without_entry", 64'(a_out_valid && q3.size() == 0), 64'(0));
      if (a_flush) begin
        q3.delete();
      end else begin
        if (a_out_valid && a_out_ready && q3.size() > 0) begin
          check("rnd3_out_data", 64'(a_out_data), 64'(q3[0]));
          void'(q3.pop_front());
        end
        if (a_in_valid && exp_rdy) q3.push_back(a_in_data);
      end

      exp_rdy = b_out_ready || q1.size() < D1;
      check("rnd1_count",     64'(b_count),     64'(q1.size()));
      check("rnd1_in_ready",  64'(b_in_ready),  64'(exp_rdy));
      check("rnd1_out_valid", 64'(b_out_valid), 64'(q1.size() > 0));
      if (b_out_valid && b_out_ready && q1.size() > 0) begin
        check("rnd1_out_data", 64'(b_out_data), 64'(q1[0]));
        void'(q1.pop_front());
      end
      if (b_in_valid && exp_rdy) q1.push_back(b_in_data);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_register
